// File: rtl/thread_dispatch_sched_if.sv
// Handshake bundle between the per-thread decode queues, the issue scheduler and the ALU issue ports.
// The slave modport is the scheduler side; the master modport is the side that feeds it and observes its outputs.
interface thread_dispatch_sched_if #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_ALUS    = 3,
    parameter int TID_W       = 3,
    parameter int PTR_W       = 2,
    parameter int CNT_W       = 2
);
    logic [NUM_THREADS-1:0]           thread_valid;
    logic [NUM_THREADS-1:0]           thread_hazard;
    logic [NUM_THREADS-1:0]           thread_done;
    logic [NUM_ALUS-1:0]              alu_ready;
    logic [NUM_THREADS-1:0]           thread_issue;
    logic [NUM_ALUS-1:0][TID_W-1:0]   dispatch_threads;
    logic [CNT_W-1:0]                 issue_count;
    logic [31:0]                      issue_total;
    logic [PTR_W-1:0]                 rr_ptr;

    modport master (
        output thread_valid, thread_hazard, thread_done, alu_ready,
        input  thread_issue, dispatch_threads, issue_count, issue_total, rr_ptr
    );

    modport slave (
        input  thread_valid, thread_hazard, thread_done, alu_ready,
        output thread_issue, dispatch_threads, issue_count, issue_total, rr_ptr
    );
endinterface

// File: rtl/thread_dispatch_sched.sv
// Round-robin issue scheduler: binds up to NUM_ALUS eligible threads per cycle to free ALUs
// in ascending ALU order and registers the per-ALU thread tags.
module thread_dispatch_sched #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_ALUS    = 3,
    parameter int TID_W       = 3,
    parameter int IDLE_ID     = 4,
    parameter int ISSUE_GAP   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    thread_dispatch_sched_if.slave bus
);
    localparam int PTR_W  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int ALU_W  = (NUM_ALUS > 1) ? $clog2(NUM_ALUS) : 1;
    localparam int CNT_W  = $clog2(NUM_ALUS + 1);
    localparam int COOL_W = 3;
    localparam logic [TID_W-1:0] IDLE_TAG = TID_W'(IDLE_ID);

    logic [NUM_THREADS-1:0]         elig;
    logic [NUM_THREADS-1:0]         grant;
    logic [PTR_W-1:0]               rr_q, rr_d;
    logic [NUM_ALUS-1:0][TID_W-1:0] disp_q, disp_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [31:0]                    issue_total_q, issue_total_d;
    logic [32:0]                    total_sum;

    // Per-thread eligibility and post-issue cooldown counter.
    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
        logic [COOL_W-1:0] cool_q, cool_d;

        assign elig[gi] = bus.thread_valid[gi] & ~bus.thread_hazard[gi]
                        & ~bus.thread_done[gi] & (cool_q == '0);

        always_comb begin
            cool_d = cool_q;
            if (grant[gi]) begin
                cool_d = COOL_W'(ISSUE_GAP);
            end else if (cool_q != '0) begin
                cool_d = cool_q - COOL_W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cool_q <= '0;
            end else begin
                cool_q <= cool_d;
            end
        end
    end

    // Walk threads from rr_q; each eligible one takes the lowest ready ALU not yet claimed.
    always_comb begin
        int   tid;
        int   last_tid;
        logic placed;
        logic any_grant;
        logic [NUM_ALUS-1:0] alu_taken;

        grant     = '0;
        disp_d    = {NUM_ALUS{IDLE_TAG}};
        cnt_d     = '0;
        tid       = 0;
        last_tid  = 0;
        placed    = 1'b0;
        any_grant = 1'b0;
        alu_taken = '0;

        for (int k = 0; k < NUM_THREADS; k++) begin
            tid = int'(rr_q) + k;
            if (tid >= NUM_THREADS) begin
                tid = tid - NUM_THREADS;
            end
            placed = 1'b0;
            if (elig[PTR_W'(tid)]) begin
                for (int j = 0; j < NUM_ALUS; j++) begin
                    if (!placed && bus.alu_ready[ALU_W'(j)] && !alu_taken[ALU_W'(j)]) begin
                        placed                = 1'b1;
                        alu_taken[ALU_W'(j)]  = 1'b1;
                        disp_d[ALU_W'(j)]     = TID_W'(tid);
                    end
                end
            end
            if (placed) begin
                grant[PTR_W'(tid)] = 1'b1;
                cnt_d              = cnt_d + CNT_W'(1);
                last_tid           = tid;
                any_grant          = 1'b1;
            end
        end

        rr_d = any_grant ? PTR_W'((last_tid + 1) % NUM_THREADS) : rr_q;
    end

    assign total_sum     = {1'b0, issue_total_q} + {{(33 - CNT_W){1'b0}}, cnt_d};
    assign issue_total_d = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q          <= '0;
            disp_q        <= {NUM_ALUS{IDLE_TAG}};
            cnt_q         <= '0;
            issue_total_q <= '0;
        end else begin
            rr_q          <= rr_d;
            disp_q        <= disp_d;
            cnt_q         <= cnt_d;
            issue_total_q <= issue_total_d;
        end
    end

    // Pops are suppressed while reset is held so upstream never loses an instruction.
    assign bus.thread_issue     = grant & ~{NUM_THREADS{rst}};
    assign bus.dispatch_threads = disp_q;
    assign bus.issue_count      = cnt_q;
    assign bus.issue_total      = issue_total_q;
    assign bus.rr_ptr           = rr_q;
endmodule

// File: tb/tb_thread_dispatch_sched.sv
// Scoreboard bench for thread_dispatch_sched: a reference model predicts grants and registered outputs
// per cycle; a second instance with ISSUE_GAP=2 exercises the cooldown path.
module tb_thread_dispatch_sched;
    localparam int NT = 4;
    localparam int NA = 3;
    localparam int TW = 3;
    localparam logic [2:0] IDLE = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    thread_dispatch_sched_if #(.NUM_THREADS(NT), .NUM_ALUS(NA), .TID_W(TW), .PTR_W(2), .CNT_W(2)) a_if ();
    thread_dispatch_sched_if #(.NUM_THREADS(NT), .NUM_ALUS(NA), .TID_W(TW), .PTR_W(2), .CNT_W(2)) b_if ();

    thread_dispatch_sched #(.NUM_THREADS(NT), .NUM_ALUS(NA), .TID_W(TW), .IDLE_ID(4), .ISSUE_GAP(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    thread_dispatch_sched #(.NUM_THREADS(NT), .NUM_ALUS(NA), .TID_W(TW), .IDLE_ID(4), .ISSUE_GAP(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    typedef struct {
        logic [8:0]  disp;
        logic [1:0]  cnt;
        logic [1:0]  rr;
        logic [31:0] total;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          iss_cnt[NT];
    logic [1:0]  m_rr = 2'd0;
    logic [31:0] m_total = 32'd0;
    logic [3:0]  last_issue = 4'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] slots(input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2);
        return {s2, s1, s0};
    endfunction

    // One cycle on dut_a: drive at negedge, predict, check pop strobe, then check registered outputs.
    task automatic step_a(input logic [3:0] v, input logic [3:0] h, input logic [3:0] d, input logic [2:0] r);
        logic [3:0]  elig;
        logic [3:0]  exp_iss;
        logic [3:0]  obs_iss;
        logic [8:0]  ed;
        logic [32:0] s;
        logic [1:0]  ti;
        logic        found;
        int          cursor;
        int          t;
        int          cnt;
        int          last;
        exp_t        e;
        exp_t        got;

        @(negedge clk);
        a_if.thread_valid  = v;
        a_if.thread_hazard = h;
        a_if.thread_done   = d;
        a_if.alu_ready     = r;
        #1;

        elig    = v & ~h & ~d;
        exp_iss = 4'd0;
        ed      = {IDLE, IDLE, IDLE};
        cursor  = 0;
        cnt     = 0;
        last    = 0;
        for (int j = 0; j < NA; j++) begin
            if (r[2'(j)]) begin
                found = 1'b0;
                while (!found && cursor < NT) begin
                    t = (int'(m_rr) + cursor) % NT;
                    ti = t[1:0];
                    cursor++;
                    if (elig[ti]) begin
                        found          = 1'b1;
                        ed[j*3 +: 3]   = 3'(t);
                        exp_iss[ti]    = 1'b1;
                        cnt++;
                        last = t;
                    end
                end
            end
        end
        if (cnt > 0) m_rr = 2'((last + 1) % NT);
        s = {1'b0, m_total} + 33'(cnt);
        m_total = s[32] ? 32'hFFFF_FFFF : s[31:0];
        e.disp  = ed;
        e.cnt   = 2'(cnt);
        e.rr    = m_rr;
        e.total = m_total;

        obs_iss    = a_if.thread_issue;
        last_issue = obs_iss;
        check("thread_issue", 32'(obs_iss), 32'(exp_iss));
        for (int i = 0; i < NT; i++) begin
            if (obs_iss[2'(i)]) iss_cnt[i]++;
        end
        sb.push_back(e);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("dispatch_threads", 32'(a_if.dispatch_threads), 32'(got.disp));
        check("issue_count", 32'(a_if.issue_count), 32'(got.cnt));
        check("rr_ptr", 32'(a_if.rr_ptr), 32'(got.rr));
        check("issue_total", a_if.issue_total, got.total);
        $display("txn v=%b h=%b d=%b r=%b issue=%b slots=%h cnt=%0d rr=%0d total=%0h",
                 v, h, d, r, obs_iss, a_if.dispatch_threads, a_if.issue_count, a_if.rr_ptr, a_if.issue_total);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        a_if.thread_valid  = 4'b1111;
        a_if.thread_hazard = 4'b0000;
        a_if.thread_done   = 4'b0000;
        a_if.alu_ready     = 3'b111;
        b_if.thread_valid  = 4'b0000;
        b_if.thread_hazard = 4'b0000;
        b_if.thread_done   = 4'b0000;
        b_if.alu_ready     = 3'b111;
        for (int i = 0; i < NT; i++) iss_cnt[i] = 0;

        // Reset held for two cycles with everything requesting.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_issue", 32'(a_if.thread_issue), 32'd0);
        check("rst_dispatch", 32'(a_if.dispatch_threads), 32'(slots(IDLE, IDLE, IDLE)));
        check("rst_count", 32'(a_if.issue_count), 32'd0);
        check("rst_total", a_if.issue_total, 32'd0);
        check("rst_rr", 32'(a_if.rr_ptr), 32'd0);
        rst = 1'b0;

        // Full round-robin over four cycles.
        step_a(4'b1111, 4'b0000, 4'b0000, 3'b111);
        check("rr_c0_slots", 32'(a_if.dispatch_threads), 32'(slots(3'd0, 3'd1, 3'd2)));
        check("rr_c0_ptr", 32'(a_if.rr_ptr), 32'd3);
        step_a(4'b1111, 4'b0000, 4'b0000, 3'b111);
        check("rr_c1_slots", 32'(a_if.dispatch_threads), 32'(slots(3'd3, 3'd0, 3'd1)));
        step_a(4'b1111, 4'b0000, 4'b0000, 3'b111);
        check("rr_c2_slots", 32'(a_if.dispatch_threads), 32'(slots(3'd2, 3'd3, 3'd0)));
        step_a(4'b1111, 4'b0000, 4'b0000, 3'b111);
        check("rr_c3_slots", 32'(a_if.dispatch_threads), 32'(slots(3'd1, 3'd2, 3'd3)));
        check("rr_total12", a_if.issue_total, 32'd12);
        for (int i = 0; i < NT; i++) check("rr_per_thread", 32'(iss_cnt[i]), 32'd3);

        // Move rr_ptr to 1, then partial ALU availability.
        step_a(4'b0001, 4'b0000, 4'b0000, 3'b111);
        check("rr_to_1", 32'(a_if.rr_ptr), 32'd1);
        step_a(4'b0110, 4'b0000, 4'b0000, 3'b101);
        check("partial_slots", 32'(a_if.dispatch_threads), 32'(slots(3'd1, IDLE, 3'd2)));
        check("partial_count", 32'(a_if.issue_count), 32'd2);
        check("partial_rr", 32'(a_if.rr_ptr), 32'd3);

        // Hazard on thread 0, thread 2 done (still valid).
        step_a(4'b1111, 4'b0001, 4'b0100, 3'b111);
        check("mask_issue", 32'(last_issue), 32'(4'b1010));
        check("mask_slot2", 32'(a_if.dispatch_threads[2]), 32'(IDLE));

        // No ALU ready: everything idles, pointer held.
        step_a(4'b1111, 4'b0000, 4'b0000, 3'b000);
        check("noalu_slots", 32'(a_if.dispatch_threads), 32'(slots(IDLE, IDLE, IDLE)));
        check("noalu_rr", 32'(a_if.rr_ptr), 32'd2);

        // Cooldown on the ISSUE_GAP=2 instance while dut_a idles.
        a_if.thread_valid = 4'b0000;
        b_if.thread_valid = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            #1;
            check("cool_issue", 32'(b_if.thread_issue[0]), 32'((c % 3) == 0));
            $display("txn cool cycle=%0d issue=%b", c, b_if.thread_issue);
            @(posedge clk);
            #1;
        end
        check("cool_total", b_if.issue_total, 32'd3);
        b_if.thread_valid = 4'b0000;

        // Random traffic against the model.
        for (int n = 0; n < 40; n++) begin
            step_a(4'($urandom), 4'($urandom) & 4'($urandom), 4'($urandom) & 4'($urandom), 3'($urandom));
        end

        // Saturation of issue_total.
        step_a(4'b0000, 4'b0000, 4'b0000, 3'b000);
        force dut_a.issue_total_q = 32'hFFFF_FFFE;
        #1;
        release dut_a.issue_total_q;
        m_total = 32'hFFFF_FFFE;
        step_a(4'b1111, 4'b0000, 4'b0000, 3'b111);
        check("sat_reach", a_if.issue_total, 32'hFFFF_FFFF);
        step_a(4'b1111, 4'b0000, 4'b0000, 3'b111);
        check("sat_hold", a_if.issue_total, 32'hFFFF_FFFF);

        // Asynchronous reset between clock edges while grants are live.
        @(negedge clk);
        a_if.thread_valid  = 4'b1111;
        a_if.thread_hazard = 4'b0000;
        a_if.thread_done   = 4'b0000;
        a_if.alu_ready     = 3'b111;
        #2;
        rst = 1'b1;
        #1;
        check("arst_issue", 32'(a_if.thread_issue), 32'd0);
        check("arst_dispatch", 32'(a_if.dispatch_threads), 32'(slots(IDLE, IDLE, IDLE)));
        check("arst_count", 32'(a_if.issue_count), 32'd0);
        check("arst_total", a_if.issue_total, 32'd0);
        check("arst_rr", 32'(a_if.rr_ptr), 32'd0);
        m_rr    = 2'd0;
        m_total = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step_a(4'b1111, 4'b0000, 4'b0000, 3'b111);
        check("post_rst_slots", 32'(a_if.dispatch_threads), 32'(slots(3'd0, 3'd1, 3'd2)));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/thread_dispatch_sched.md
# thread_dispatch_sched

Per-cycle issue scheduler for the 4-thread, 3-ALU RISC-V core. Each cycle it picks up to NUM_ALUS eligible hardware threads in round-robin order and binds each one to a free ALU. It drives the registered `dispatch_threads` vector that the core exports for per-ALU thread tagging and IPC measurement. It sits between the per-thread fetch/decode queues (upstream) and the ALU issue ports (downstream).

## Interface
- NUM_THREADS, 4, hardware thread count; thread IDs 0..NUM_THREADS-1.
- NUM_ALUS, 3, ALU issue slots per cycle.
- TID_W, 3, width of a thread tag; must satisfy 2^TID_W > NUM_THREADS.
- IDLE_ID, 4, tag value meaning "slot idle"; must be ≥ NUM_THREADS.
- ISSUE_GAP, 0, extra cycles a thread must wait after an issue before it may issue again (0..7).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- thread_valid  in  NUM_THREADS  thread i has a decoded instruction ready.
- thread_hazard  in  NUM_THREADS  thread i's head instruction is blocked on an unresolved operand.
- thread_done  in  NUM_THREADS  thread i has halted; overrides thread_valid.
- alu_ready  in  NUM_ALUS  ALU j can accept an instruction this cycle.
- thread_issue  out  NUM_THREADS  combinational pop strobe: thread i is granted this cycle.
- dispatch_threads  out  NUM_ALUS × TID_W  registered: thread tag bound to ALU j, or IDLE_ID.
- issue_count  out  2  registered: number of non-idle entries in dispatch_threads.
- issue_total  out  32  saturating count of all issued instructions since reset.
- rr_ptr  out  2  current round-robin start thread.

## Operation
- Eligibility: elig[i] = thread_valid[i] & ~thread_hazard[i] & ~thread_done[i] & (cool[i] == 0).
- Candidate order: threads rr_ptr, rr_ptr+1, … modulo NUM_THREADS.
- Free ALUs are filled in ascending ALU index. The k-th eligible thread in candidate order goes to the k-th ALU with alu_ready=1.
- A thread is granted at most once per cycle (in-order per thread).
- Ungranted eligible threads are not popped. They stay pending with no penalty.
- thread_issue[i] = 1 in the same cycle that thread i is granted. Upstream pops on the same rising edge.
- On the rising edge, dispatch_threads[j] loads the granted tag, or IDLE_ID if ALU j is not ready or unfilled. issue_count loads the grant count.
- rr_ptr update: loads (last granted thread + 1) mod NUM_THREADS. It holds if there is no grant. This guarantees starvation-freedom.
- Cooldown:
  - On grant, cool[i] loads ISSUE_GAP.
  - Otherwise, if cool[i] > 0, it decrements by 1 each cycle.
  - With ISSUE_GAP=0, a thread may issue every cycle.
- issue_total adds the grant count (0..3) every cycle and saturates at 0xFFFF_FFFF with no wrap.
- The block has no FSM beyond this per-cycle state: rr_ptr, cool[], the output registers, and issue_total.

## Timing
- Reset values (asynchronous, take effect immediately while rst=1):
  - dispatch_threads all = IDLE_ID
  - issue_count = 0
  - issue_total = 0
  - rr_ptr = 0
  - all cool = 0
  - thread_issue forced to 0
- Latency: an eligible thread seen in cycle t has thread_issue asserted in cycle t. Its tag appears on dispatch_threads in cycle t+1.
- Reset asserted mid-operation:
  - In-cycle grants are discarded.
  - Outputs take their reset values within the same cycle.
  - No pop occurs, because thread_issue is gated by rst.
  - The first grant is possible in the first cycle after rst deasserts.
- All alu_ready=0: no grants, every slot is IDLE_ID next cycle, rr_ptr held, cooldowns still decrement.
- More eligible threads than free ALUs: the lowest-priority eligible thread waits. It becomes first candidate next cycle via the rr_ptr update.
- thread_valid and thread_done both set: the thread is not eligible.
- thread_hazard toggling in cycle t affects the cycle-t grant only (the path is combinational).
- Saturation: issue_total stays at 0xFFFF_FFFF once reached.

## Test plan
- Reset/idle: hold rst=1 for 2 cycles with all inputs at 1 → thread_issue=0, dispatch_threads={4,4,4}, issue_count=0, issue_total=0. Then release rst → next cycle dispatch_threads={0,1,2}, rr_ptr=3.
- Full round-robin: all 4 threads eligible, all ALUs ready, ISSUE_GAP=0 for 4 cycles → slots go {0,1,2}, {3,0,1}, {2,3,0}, {1,2,3}. issue_total=12 and every thread issues exactly 3 times.
- Partial ALUs: alu_ready=3'b101 with threads 1 and 2 eligible and rr_ptr=1 → next cycle dispatch_threads = {1, 4, 2}, issue_count=2, rr_ptr=3.
- Hazard/done masking: thread_hazard[0]=1, thread_done[2]=1, others valid → only threads 1 and 3 are granted, thread_issue=4'b1010, and slot 2 = IDLE_ID.
- Cooldown: ISSUE_GAP=2 with only thread 0 valid continuously → thread 0 issues in cycles 0, 3, 6. Over 9 cycles issue_total=3.
- Saturation and mid-run reset: preload issue_total near its maximum via force to 0xFFFF_FFFE, then issue 3 → reads 0xFFFF_FFFF. Assert rst asynchronously between clock edges → all outputs reach reset values before the next rising edge.
